// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- single-cycle ALU with a sequential unsigned multiply/divide unit.
//
// The single-cycle ALU result is purely combinational from a, b and alucont.
// It stays valid while a multi-cycle operation runs. MULTU uses a shift-add
// multiplier and DIVU uses a restoring divider. Each retires one bit per
// cycle over WIDTH cycles and writes {hi,lo} on the edge that enters DONE.
//
// Configuration macro:
//   SEQ_ALU_DIV_EN  defined   -> DIVU implemented (lo = quotient, hi = remainder)
//                   undefined -> no divider logic; DIVU starts are ignored
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   a, b     in   operands (WIDTH bits)
//   alucont  in   operation select (4 bits)
//   start    in   launch request for MULTU (1000) / DIVU (1001)
//   result   out  combinational single-cycle result
//   zero     out  result == 0
//   busy     out  multiply/divide in progress
//   done     out  one-cycle pulse, hi/lo just updated
//   hi, lo   out  registered product halves, or remainder/quotient
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, next_state;
  logic [WIDTH-1:0] acc_q;   // running product high half / partial remainder
  logic [WIDTH-1:0] qr_q;    // multiplier bits shifting out / quotient shifting in
  logic [WIDTH-1:0] b_q;     // latched multiplicand / divisor
  logic [CW-1:0]    cnt_q;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] diff;
  logic             slt_ovf;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    diff    = a - b;
    // Signed overflow of a-b: operand signs differ and the difference's sign
    // disagrees with a. The true signed comparison is sign(diff) ^ overflow.
    slt_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    result  = '0;
    case (alucont)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: result = a + b;
      4'b0011: result = a ^ b;
      4'b0100: result = ~(a | b);
      4'b0101: result = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0110: result = diff;
      4'b0111: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ slt_ovf};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic can_start, launch_mul, launch_div, last;

  assign can_start  = start && ((state_q == IDLE) || (state_q == DONE));
  assign launch_mul = can_start && (alucont == 4'b1000);
`ifdef SEQ_ALU_DIV_EN
  assign launch_div = can_start && (alucont == 4'b1001);
`else
  assign launch_div = 1'b0;
`endif
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE, DONE: begin
        if      (launch_mul) next_state = MUL;
        else if (launch_div) next_state = DIV;
        else                 next_state = IDLE;
      end
      MUL:     if (last) next_state = DONE;
      DIV:     if (last) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state_q == MUL) || (state_q == DIV);
  assign done = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // One-bit-per-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_acc, step_qr;

  // Shift-add: conditionally add the multiplicand into the high half, then
  // shift {carry, acc, qr} right one place. After WIDTH steps {acc,qr} holds
  // the full product.
  assign mul_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_q} : '0);

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. When it fits the difference is
  // below b, so a WIDTH-bit subtraction is exact. A zero divisor always
  // "fits", which yields quotient all ones and remainder equal to a.
  assign div_shift = {acc_q, qr_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    if (state_q == DIV) begin
      step_acc = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_qr  = {qr_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_qr  = {mul_sum[0], qr_q[WIDTH-1:1]};
    end
  end
`else
  assign step_acc = mul_sum[WIDTH:1];
  assign step_qr  = {mul_sum[0], qr_q[WIDTH-1:1]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      qr_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (launch_mul || launch_div) begin
      acc_q <= '0;
      qr_q  <= a;
      b_q   <= b;
      cnt_q <= '0;
    end else if (busy) begin
      acc_q <= step_acc;
      qr_q  <= step_qr;
      cnt_q <= cnt_q + CW'(1);
      // hi/lo move only on the edge into DONE.
      if (last) begin
        hi <= step_acc;
        lo <= step_qr;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH = 8).
// Random and directed stimulus is compared against a plain-arithmetic
// reference model. DIVU expectations follow SEQ_ALU_DIV_EN.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 8;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic [3:0]   alucont;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alucont(alucont), .start(start),
    .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Model of the registered hi/lo outputs.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the operation definitions using integer arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [3:0] op);
    int ux, uy, sx, sy, m, r;
    m  = 1 << W;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    case (op)
      4'd0:    r = ux & uy;
      4'd1:    r = ux | uy;
      4'd2:    r = (ux + uy) % m;
      4'd3:    r = ux ^ uy;
      4'd4:    r = (m - 1) - (ux | uy);
      4'd5:    r = (ux < uy) ? 1 : 0;
      4'd6:    r = (ux - uy + m) % m;
      4'd7:    r = (sx < sy) ? 1 : 0;
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  task automatic ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op,
                        output logic [W-1:0] eh, output logic [W-1:0] el);
    longint p;
    if (op == OP_MULTU) begin
      p  = longint'(x) * longint'(y);
      eh = W'(p / (longint'(1) << W));
      el = W'(p % (longint'(1) << W));
    end else if (y == '0) begin
      eh = x;
      el = '1;
    end else begin
      eh = x % y;
      el = x / y;
    end
  endtask

  task automatic comb_check(input string tag);
    logic [W-1:0] exp_r;
    #1;
    exp_r = ref_result(a, b, alucont);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_zero"}, 32'(zero), 32'(exp_r == '0));
  endtask

  // Called at a negedge; raises start for one edge and follows the operation
  // to its DONE cycle (returns at the negedge inside DONE), or, for a start
  // that must be ignored, watches that nothing happens. With disturb set, a
  // second start with other operands is issued during busy.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op,
                        input bit disturb, input string tag);
    logic [W-1:0] eh, el;
    int edges, busy_n, hold_bad, quiet_bad;
    bit launch;
    launch  = (op == OP_MULTU) || (op == OP_DIVU && DIV_EN);
    a       = x;
    b       = y;
    alucont = op;
    start   = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    edges  = 1;
    busy_n = 0;
    hold_bad = 0;
    if (!launch) begin
      quiet_bad = 0;
      for (int i = 0; i < W + 3; i++) begin
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) quiet_bad++;
        @(negedge clk);
      end
      check({tag, "_ignored"}, 32'(quiet_bad), 32'(0));
      alucont = op;
      comb_check({tag, "_ign"});
      return;
    end
    while (done !== 1'b1 && edges <= 3 * W) begin
      if (busy === 1'b1) busy_n++;
      if (hi !== m_hi || lo !== m_lo) hold_bad++;
      a       = W'($urandom);
      b       = W'($urandom);
      alucont = 4'($urandom_range(0, 15));
      comb_check({tag, "_busy"});
      if (disturb && edges == 3) begin
        a       = ~x;
        b       = y + W'(1);
        alucont = op;
        start   = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, "_hold"}, 32'(hold_bad), 32'(0));
    check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
    ref_op(x, y, op, eh, el);
    m_hi = eh;
    m_lo = el;
    check({tag, "_hi"}, 32'(hi), 32'(eh));
    check({tag, "_lo"}, 32'(lo), 32'(el));
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic [3:0]   rop;
    int           done_seen;

    reset   = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    alucont = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_hi", 32'(hi), 32'(0));
    check("rst_lo", 32'(lo), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed comparison corner cases.
    a = 8'h7F; b = 8'h80; alucont = 4'd7; #1;
    check("slt_7f_80", 32'(result), 32'h00);
    check("slt_7f_80_zero", 32'(zero), 32'd1);
    alucont = 4'd5; #1;
    check("sltu_7f_80", 32'(result), 32'h01);
    a = 8'h80; b = 8'h01; alucont = 4'd7; #1;
    check("slt_80_01", 32'(result), 32'h01);

    // Every opcode, random operands.
    for (int i = 0; i < 96; i++) begin
      a       = W'($urandom);
      b       = (i % 8 == 0) ? a : W'($urandom);
      alucont = 4'(i % 16);
      comb_check("comb");
    end
    @(negedge clk);

    run_op(8'hFF, 8'hFF, OP_MULTU, 1'b0, "mul_ff_ff");
    check("mul_ff_ff_hi_const", 32'(hi), 32'hFE);
    check("mul_ff_ff_lo_const", 32'(lo), 32'h01);
    @(negedge clk);

    run_op(8'h64, 8'h07, OP_DIVU, 1'b0, "div_64_07");
    if (DIV_EN) begin
      check("div_64_07_lo_const", 32'(lo), 32'h0E);
      check("div_64_07_hi_const", 32'(hi), 32'h02);
    end
    @(negedge clk);
    run_op(8'h05, 8'h00, OP_DIVU, 1'b0, "div_by_zero");
    @(negedge clk);

    // Start during busy is ignored.
    run_op(8'h0D, 8'h0B, OP_MULTU, 1'b1, "mul_disturb");
    // Start in the DONE cycle: next op begins immediately.
    run_op(8'hC3, 8'h11, OP_DIVU, 1'b1, "b2b_div");
    run_op(8'hA5, 8'h5A, OP_MULTU, 1'b0, "b2b_mul");
    @(negedge clk);

    // Reset in the 4th busy cycle.
    a = 8'h37; b = 8'h29; alucont = OP_MULTU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_done", 32'(done), 32'(0));
    check("rstmid_hi", 32'(hi), 32'(0));
    check("rstmid_lo", 32'(lo), 32'(0));
    done_seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("rstmid_no_done", 32'(done_seen), 32'(0));

    // Reset wins over start in the same cycle.
    a = 8'h12; b = 8'h34; alucont = OP_MULTU; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("rst_vs_start_busy2", 32'(busy), 32'(0));

    // Random operation stream, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      rx  = W'($urandom);
      ry  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      rop = ($urandom_range(0, 1) == 1) ? OP_MULTU : OP_DIVU;
      run_op(rx, ry, rop, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) != 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
